// File: rtl/display_spi_rx_if.sv
// display_spi_rx_if: serial display-link pins plus the received-byte handshake of display_spi_rx
// Signals: SCLK/nCS/DnC/SDIN serial inputs; RxData/RxDnC/RxValid/RxReady byte handshake;
//          Overrun/FrameError one-cycle status pulses.
// Modports: slave = the receiver, master = the environment driving the link and consuming bytes.
interface display_spi_rx_if;
  logic       SCLK;
  logic       nCS;
  logic       DnC;
  logic       SDIN;
  logic [7:0] RxData;
  logic       RxDnC;
  logic       RxValid;
  logic       RxReady;
  logic       Overrun;
  logic       FrameError;
  modport master (
    output SCLK, nCS, DnC, SDIN, RxReady,
    input  RxData, RxDnC, RxValid, Overrun, FrameError
  );
  modport slave (
    input  SCLK, nCS, DnC, SDIN, RxReady,
    output RxData, RxDnC, RxValid, Overrun, FrameError
  );
endinterface

// File: rtl/display_spi_rx.sv
// display_spi_rx: SPI display-link byte receiver with a ready/valid output store
// Ports: Clock (rising edge), nReset (async, active-low),
//        bus (display_spi_rx_if.slave): SCLK/nCS/DnC/SDIN in, RxData/RxDnC/RxValid out,
//        RxReady in, Overrun/FrameError one-cycle pulses out.
// Config: define DISPLAY_SPI_RX_FIFO_EN for a 4-entry FIFO store; default is one holding register.
module display_spi_rx (
  input logic             Clock,
  input logic             nReset,
  display_spi_rx_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} rxState;
  rxState     state;
  logic [1:0] sclkSync, ncsSync, dncSync, sdinSync;
  logic       sclkPrev;
  logic [1:0] fill;
  logic       armed;
  logic       sclkRise;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic       pushValid;
  logic [8:0] pushData;
  logic       frameError;
  logic       overrun;
  logic       pop;
  logic       accept;

  assign sclkRise = sclkSync[1] & ~sclkPrev & ~ncsSync[1];

  // fill marks when the synchronisers carry real pin values again after reset;
  // armed then waits for nCS high so a frame already active at release is ignored.
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      sclkSync <= 2'b00;
      ncsSync  <= 2'b11;
      dncSync  <= 2'b00;
      sdinSync <= 2'b00;
      sclkPrev <= 1'b0;
      fill     <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[0], bus.SCLK};
      ncsSync  <= {ncsSync[0], bus.nCS};
      dncSync  <= {dncSync[0], bus.DnC};
      sdinSync <= {sdinSync[0], bus.SDIN};
      sclkPrev <= sclkSync[1];
      fill     <= {fill[0], 1'b1};
      armed    <= armed | (fill[1] & ncsSync[1]);
    end

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      state      <= IDLE;
      bitCnt     <= 3'd0;
      shiftReg   <= 8'd0;
      pushValid  <= 1'b0;
      pushData   <= 9'd0;
      frameError <= 1'b0;
    end else begin
      pushValid  <= 1'b0;
      frameError <= 1'b0;
      if (state == IDLE) begin
        if (armed && !ncsSync[1]) begin
          state    <= SHIFT;
          bitCnt   <= 3'd0;
          shiftReg <= 8'd0;
        end
      end else if (ncsSync[1]) begin
        state      <= IDLE;
        frameError <= bitCnt != 3'd0;
      end else if (sclkRise) begin
        shiftReg <= {shiftReg[6:0], sdinSync[1]};
        bitCnt   <= bitCnt + 3'd1;
        if (bitCnt == 3'd7) begin
          pushValid <= 1'b1;
          pushData  <= {dncSync[1], shiftReg[6:0], sdinSync[1]};
        end
      end
    end

`ifdef DISPLAY_SPI_RX_FIFO_EN
  logic [8:0] mem [4];
  logic [1:0] wrPtr, rdPtr;
  logic [2:0] count;
  logic       full;

  assign full   = count[2];
  assign pop    = (count != 3'd0) & bus.RxReady;
  assign accept = pushValid & (~full | pop);

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      for (int i = 0; i < 4; i++) mem[i] <= 9'd0;
      wrPtr   <= 2'd0;
      rdPtr   <= 2'd0;
      count   <= 3'd0;
      overrun <= 1'b0;
    end else begin
      overrun <= pushValid & ~accept;
      if (accept) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 2'd1;
      end
      if (pop) rdPtr <= rdPtr + 2'd1;
      count <= count + {2'd0, accept} - {2'd0, pop};
    end

  assign {bus.RxDnC, bus.RxData} = mem[rdPtr];
  assign bus.RxValid             = count != 3'd0;
`else
  logic [8:0] hold;
  logic       holdValid;

  assign pop    = holdValid & bus.RxReady;
  assign accept = pushValid & (~holdValid | pop);

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      hold      <= 9'd0;
      holdValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun   <= pushValid & ~accept;
      if (accept) hold <= pushData;
      holdValid <= accept | (holdValid & ~pop);
    end

  assign {bus.RxDnC, bus.RxData} = hold;
  assign bus.RxValid             = holdValid;
`endif

  assign bus.Overrun    = overrun;
  assign bus.FrameError = frameError;
endmodule

// File: tb/tb_display_spi_rx.sv
// tb_display_spi_rx: randomized self-checking bench for display_spi_rx against a queue model
module tb_display_spi_rx;
`ifdef DISPLAY_SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  logic Clock = 1'b0;
  logic nReset = 1'b0;
  display_spi_rx_if bus();
  display_spi_rx dut (.Clock(Clock), .nReset(nReset), .bus(bus.slave));
  always #5 Clock = ~Clock;

  int         cyc = 0, checks = 0, errors = 0;
  logic [8:0] mq[$];
  logic [8:0] gotQ[$];
  logic [8:0] expQ[$];
  logic [8:0] pushAt[int];
  bit         feAt[int];
  logic       ovExp = 1'b0, feExp = 1'b0;
  bit         popNow;
  int         ovCount = 0, feCount = 0, bitsInFrame = 0;
  int         lastEdgeCyc = 0, latency = 0;
  int         readyMode = 0, readyCycle = -1;
  logic       prevValid = 1'b0;
  int         ov0, fe0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic checkGot(input string name);
    check({name, " count"}, 32'(gotQ.size()), 32'(expQ.size()));
    foreach (expQ[i]) check(name, i < gotQ.size() ? 32'(gotQ[i]) : 32'hFFFF_FFFF, 32'(expQ[i]));
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // A pin change made just after edge n reaches the store at edge n+4; a frame abort pulses at n+3.
  always @(posedge Clock) begin
    cyc++;
    if (!nReset) begin
      mq.delete();
      pushAt.delete();
      feAt.delete();
      ovExp = 1'b0;
      feExp = 1'b0;
    end else begin
      popNow = mq.size() > 0 && bus.RxReady === 1'b1;
      if (popNow) void'(mq.pop_front());
      ovExp = 1'b0;
      if (pushAt.exists(cyc)) begin
        if (mq.size() < CAP) mq.push_back(pushAt[cyc]);
        else ovExp = 1'b1;
        pushAt.delete(cyc);
      end
      feExp = feAt.exists(cyc) != 0;
      if (feExp) feAt.delete(cyc);
    end
  end

  always @(negedge Clock) begin
    if (!nReset)
      check("reset outputs", 32'({bus.RxData, bus.RxDnC, bus.RxValid, bus.Overrun, bus.FrameError}), 32'd0);
    else begin
      check("RxValid", 32'(bus.RxValid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("RxDnC/RxData", 32'({bus.RxDnC, bus.RxData}), 32'(mq[0]));
      check("Overrun", 32'(bus.Overrun), 32'(ovExp));
      check("FrameError", 32'(bus.FrameError), 32'(feExp));
      if (bus.Overrun) ovCount++;
      if (bus.FrameError) feCount++;
      if (bus.RxValid && bus.RxReady) gotQ.push_back({bus.RxDnC, bus.RxData});
      if (bus.RxValid && !prevValid && latency < 0) latency = cyc - lastEdgeCyc;
    end
    prevValid = bus.RxValid;
  end

  always @(posedge Clock) begin
    #1;
    case (readyMode)
      0:       bus.RxReady = 1'b0;
      1:       bus.RxReady = 1'b1;
      2:       bus.RxReady = (cyc + 1 == readyCycle);
      default: bus.RxReady = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic frameStart();
    bus.nCS = 1'b0;
    bitsInFrame = 0;
    tick(4);
  endtask

  task automatic frameEnd();
    tick(3);
    bus.nCS = 1'b1;
    if (bitsInFrame % 8 != 0) feAt[cyc + 3] = 1'b1;
    tick(6);
  endtask

  task automatic sendBits(input logic [7:0] b, input logic dnc, input int n);
    for (int i = 0; i < n; i++) begin
      bus.SDIN = b[7 - i];
      bus.DnC  = dnc;
      tick($urandom_range(3, 5));
      bus.SCLK = 1'b1;
      bitsInFrame++;
      if (bitsInFrame % 8 == 0) begin
        pushAt[cyc + 4] = {dnc, b};
        lastEdgeCyc = cyc;
        readyCycle  = cyc + 4;
      end
      tick($urandom_range(3, 5));
      bus.SCLK = 1'b0;
    end
  endtask

  initial begin
    bus.SCLK = 1'b0;
    bus.nCS  = 1'b1;
    bus.DnC  = 1'b0;
    bus.SDIN = 1'b0;
    readyMode = 1;
    tick(3);
    nReset = 1'b1;
    tick(4);

    latency = -1;
    frameStart();
    sendBits(8'hAF, 1'b0, 8);
    frameEnd();
    check("first byte latency", 32'(latency > 0 && latency <= 5), 32'd1);
    expQ.push_back(9'h0AF);
    checkGot("byte AF");

    fe0 = feCount;
    frameStart();
    sendBits(8'h12, 1'b1, 8);
    sendBits(8'h34, 1'b1, 8);
    frameEnd();
    check("back-to-back frame errors", 32'(feCount - fe0), 32'd0);
    expQ.push_back(9'h112);
    expQ.push_back(9'h134);
    checkGot("back-to-back");

    fe0 = feCount;
    frameStart();
    sendBits(8'hE7, 1'b0, 5);
    frameEnd();
    check("partial byte frame errors", 32'(feCount - fe0), 32'd1);
    checkGot("partial byte");
    frameStart();
    sendBits(8'h5A, 1'b0, 8);
    frameEnd();
    expQ.push_back(9'h05A);
    checkGot("after frame error");

    readyMode = 0;
    ov0 = ovCount;
    frameStart();
    for (int v = 1; v <= 6; v++) sendBits(8'(v), 1'(v), 8);
    frameEnd();
    check("overrun pulses", 32'(ovCount - ov0), CAP == 4 ? 32'd2 : 32'd5);
    readyMode = 1;
    tick(10);
    for (int v = 1; v <= CAP; v++) expQ.push_back({1'(v), 8'(v)});
    checkGot("retained on overrun");

    readyMode = 0;
    ov0 = ovCount;
    frameStart();
    for (int i = 0; i < CAP; i++) sendBits(8'hA0 + 8'(i), 1'b1, 8);
    readyMode = 2;
    sendBits(8'hB0, 1'b0, 8);
    frameEnd();
    check("push+pop on full overruns", 32'(ovCount - ov0), 32'd0);
    readyMode = 1;
    tick(10);
    for (int i = 0; i < CAP; i++) expQ.push_back({1'b1, 8'hA0 + 8'(i)});
    expQ.push_back(9'h0B0);
    checkGot("push+pop ordering");

    fe0 = feCount;
    frameStart();
    sendBits(8'hFF, 1'b1, 4);
    nReset = 1'b0;
    tick(3);
    nReset = 1'b1;
    tick(4);
    bus.nCS = 1'b1;
    tick(6);
    check("reset mid-byte frame errors", 32'(feCount - fe0), 32'd0);
    checkGot("reset mid-byte");
    frameStart();
    sendBits(8'hC3, 1'b1, 8);
    frameEnd();
    expQ.push_back(9'h1C3);
    checkGot("after reset");

    readyMode = 3;
    repeat (25) begin
      frameStart();
      repeat ($urandom_range(1, 3)) sendBits(8'($urandom), 1'($urandom_range(0, 1)), 8);
      if ($urandom_range(0, 3) == 0) sendBits(8'($urandom), 1'b0, $urandom_range(1, 7));
      frameEnd();
    end
    readyMode = 1;
    tick(20);
    check("store drained", 32'(bus.RxValid), 32'd0);
    gotQ.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
